// File: rtl/pipeline_pkg.sv
// Shared types and widths for the five-stage pipeline.
package pipeline_pkg;

    localparam int unsigned XLEN = 64;

    typedef enum logic [3:0] {
        ADD   = 4'd0,
        SUB   = 4'd1,
        AND   = 4'd2,
        OR    = 4'd3,
        XOR   = 4'd4,
        SLL   = 4'd5,
        SRL   = 4'd6,
        SRA   = 4'd7,
        SLT   = 4'd8,
        SLTU  = 4'd9,
        PASSB = 4'd10,
        MUL   = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/ex_stage_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, always XLEN iterations.
module mul_iter
    import pipeline_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    mul_state_e      r_state;
    mul_state_e      w_next;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [XLEN-1:0] r_acc;
    logic [CW-1:0]   r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (start && !abort) w_next = BUSY;
            BUSY: begin
                if (abort)                w_next = IDLE;
                else if (r_count == LAST) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == BUSY);
        done = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && !abort) begin
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_count  <= '0;
                    end
                end
                BUSY: begin
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign product = r_acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand select, single-cycle ALU, iterative multiply with
// upstream stall, and the EX/MEM pipeline register.
module ex_stage
    import pipeline_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic            AluSrc_in,
    input  logic            MemtoReg_in,
    input  logic            RegWrite_in,
    input  logic            MemRead_in,
    input  logic            MemWrite_in,
    input  logic [3:0]      alu_op_in,
    input  logic [XLEN-1:0] rs1Data_in,
    input  logic [XLEN-1:0] rs2Data_in,
    input  logic [XLEN-1:0] immediate_in,
    input  logic [4:0]      rd_in,
    input  logic            flush_in,
    output logic            stall_out,
    output logic            valid_out,
    output logic            MemtoReg_out,
    output logic            RegWrite_out,
    output logic            MemRead_out,
    output logic            MemWrite_out,
    output logic [XLEN-1:0] alu_result_out,
    output logic [XLEN-1:0] store_data_out,
    output logic [4:0]      rd_out,
    output logic            zero_out
);

    localparam int unsigned SHW = $clog2(XLEN);

    alu_op_e         w_op;
    logic [XLEN-1:0] w_op_b;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_product;
    logic            w_mul_req;
    logic            w_start;
    logic            w_busy;
    logic            w_done;
    logic            w_stall;
    logic            w_bubble;

    assign w_op      = alu_op_e'(alu_op_in);
    assign w_op_b    = AluSrc_in ? immediate_in : rs2Data_in;
    assign w_shamt   = w_op_b[SHW-1:0];
    assign w_mul_req = valid_in && (w_op == MUL);
    assign w_start   = w_mul_req && !flush_in;

    mul_iter u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_start),
        .abort   (flush_in),
        .a       (rs1Data_in),
        .b       (w_op_b),
        .busy    (w_busy),
        .done    (w_done),
        .product (w_product)
    );

    // A MUL stalls in its launch cycle and while iterating; DONE releases the pipe.
    assign w_stall   = !flush_in && (w_busy || (w_mul_req && !w_busy && !w_done));
    assign stall_out = w_stall;
    assign w_bubble  = flush_in || !valid_in || w_stall;

    always_comb begin
        w_alu = '0;
        case (w_op)
            ADD:     w_alu = rs1Data_in + w_op_b;
            SUB:     w_alu = rs1Data_in - w_op_b;
            AND:     w_alu = rs1Data_in & w_op_b;
            OR:      w_alu = rs1Data_in | w_op_b;
            XOR:     w_alu = rs1Data_in ^ w_op_b;
            SLL:     w_alu = rs1Data_in << w_shamt;
            SRL:     w_alu = rs1Data_in >> w_shamt;
            SRA:     w_alu = $signed(rs1Data_in) >>> w_shamt;
            SLT:     w_alu = XLEN'($signed(rs1Data_in) < $signed(w_op_b));
            SLTU:    w_alu = XLEN'(rs1Data_in < w_op_b);
            PASSB:   w_alu = w_op_b;
            MUL:     w_alu = w_product;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            valid_out      <= 1'b0;
            MemtoReg_out   <= 1'b0;
            RegWrite_out   <= 1'b0;
            MemRead_out    <= 1'b0;
            MemWrite_out   <= 1'b0;
            alu_result_out <= '0;
            store_data_out <= '0;
            rd_out         <= '0;
            zero_out       <= 1'b0;
        end else begin
            valid_out      <= 1'b1;
            MemtoReg_out   <= MemtoReg_in;
            RegWrite_out   <= RegWrite_in && (rd_in != 5'd0);
            MemRead_out    <= MemRead_in;
            MemWrite_out   <= MemWrite_in;
            alu_result_out <= w_alu;
            store_data_out <= rs2Data_in;
            rd_out         <= rd_in;
            zero_out       <= (w_alu == '0);
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: vector table plus multiply/flush/reset sequences.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, AluSrc_in, MemtoReg_in, RegWrite_in, MemRead_in, MemWrite_in;
    logic [3:0]  alu_op_in;
    logic [63:0] rs1Data_in, rs2Data_in, immediate_in;
    logic [4:0]  rd_in;
    logic        flush_in;
    logic        stall_out, valid_out, MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out;
    logic [63:0] alu_result_out, store_data_out;
    logic [4:0]  rd_out;
    logic        zero_out;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    ex_stage dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .AluSrc_in      (AluSrc_in),
        .MemtoReg_in    (MemtoReg_in),
        .RegWrite_in    (RegWrite_in),
        .MemRead_in     (MemRead_in),
        .MemWrite_in    (MemWrite_in),
        .alu_op_in      (alu_op_in),
        .rs1Data_in     (rs1Data_in),
        .rs2Data_in     (rs2Data_in),
        .immediate_in   (immediate_in),
        .rd_in          (rd_in),
        .flush_in       (flush_in),
        .stall_out      (stall_out),
        .valid_out      (valid_out),
        .MemtoReg_out   (MemtoReg_out),
        .RegWrite_out   (RegWrite_out),
        .MemRead_out    (MemRead_out),
        .MemWrite_out   (MemWrite_out),
        .alu_result_out (alu_result_out),
        .store_data_out (store_data_out),
        .rd_out         (rd_out),
        .zero_out       (zero_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a, rs2, imm;
        logic        alusrc;
        logic [4:0]  rd;
        logic        rw, mr, mw, m2r;
        logic [63:0] exp_res;
    } vec_t;

    typedef struct {
        logic [63:0] res, store;
        logic [4:0]  rd;
        logic        rw, mr, mw, m2r;
    } exp_t;

    localparam int NV = 16;
    vec_t vecs[NV];
    exp_t sb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic setv(input int idx, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] rs2, input logic [63:0] imm, input logic alusrc,
                        input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                        input logic m2r, input logic [63:0] exp_res);
        vecs[idx].op = op;   vecs[idx].a = a;     vecs[idx].rs2 = rs2;
        vecs[idx].imm = imm; vecs[idx].alusrc = alusrc; vecs[idx].rd = rd;
        vecs[idx].rw = rw;   vecs[idx].mr = mr;   vecs[idx].mw = mw;
        vecs[idx].m2r = m2r; vecs[idx].exp_res = exp_res;
    endtask

    task automatic drive(input vec_t v);
        valid_in     = 1'b1;
        alu_op_in    = v.op;
        rs1Data_in   = v.a;
        rs2Data_in   = v.rs2;
        immediate_in = v.imm;
        AluSrc_in    = v.alusrc;
        rd_in        = v.rd;
        RegWrite_in  = v.rw;
        MemRead_in   = v.mr;
        MemWrite_in  = v.mw;
        MemtoReg_in  = v.m2r;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.res   = v.exp_res;
        e.store = v.rs2;
        e.rd    = v.rd;
        e.rw    = v.rw && (v.rd != 5'd0);
        e.mr    = v.mr;
        e.mw    = v.mw;
        e.m2r   = v.m2r;
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, ".scoreboard_nonempty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, ".valid_out"}, 64'(valid_out), 64'd1);
            chk({tag, ".alu_result_out"}, alu_result_out, e.res);
            chk({tag, ".zero_out"}, 64'(zero_out), 64'(e.res == 64'd0));
            chk({tag, ".store_data_out"}, store_data_out, e.store);
            chk({tag, ".rd_out"}, 64'(rd_out), 64'(e.rd));
            chk({tag, ".RegWrite_out"}, 64'(RegWrite_out), 64'(e.rw));
            chk({tag, ".MemRead_out"}, 64'(MemRead_out), 64'(e.mr));
            chk({tag, ".MemWrite_out"}, 64'(MemWrite_out), 64'(e.mw));
            chk({tag, ".MemtoReg_out"}, 64'(MemtoReg_out), 64'(e.m2r));
        end
    endtask

    function automatic vec_t mk_mul(input logic [63:0] a, input logic [63:0] b,
                                    input logic [63:0] p);
        vec_t v;
        v.op = 4'd11; v.a = a; v.rs2 = b; v.imm = 64'h55; v.alusrc = 1'b0;
        v.rd = 5'd7;  v.rw = 1'b1; v.mr = 1'b0; v.mw = 1'b0; v.m2r = 1'b0;
        v.exp_res = p;
        return v;
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the result edge.
    task automatic run_mul(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] p);
        int n_stall = 0;
        int n_edges = 0;
        int n_nonbubble = 0;
        vec_t v;
        v = mk_mul(a, b, p);
        drive(v);
        push_exp(v);
        for (int i = 0; i < 200; i++) begin
            #3;
            if (!stall_out) break;
            n_stall++;
            @(posedge clk); #1;
            n_edges++;
            if (valid_out) n_nonbubble++;
        end
        @(posedge clk); #1;
        n_edges++;
        chk({tag, ".stall_cycles"}, 64'(n_stall), 64'd65);
        chk({tag, ".result_edge"}, 64'(n_edges), 64'd66);
        chk({tag, ".bubbles_during_stall"}, 64'(n_nonbubble), 64'd0);
        check_out(tag);
    endtask

    task automatic idle_inputs();
        valid_in = 1'b0; AluSrc_in = 1'b0; MemtoReg_in = 1'b0; RegWrite_in = 1'b0;
        MemRead_in = 1'b0; MemWrite_in = 1'b0; alu_op_in = 4'd0;
        rs1Data_in = '0; rs2Data_in = '0; immediate_in = '0; rd_in = '0; flush_in = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".valid_out"}, 64'(valid_out), 64'd0);
        chk({tag, ".ctrl"}, 64'({MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out}), 64'd0);
        chk({tag, ".alu_result_out"}, alu_result_out, 64'd0);
        chk({tag, ".store_data_out"}, store_data_out, 64'd0);
        chk({tag, ".rd_out"}, 64'(rd_out), 64'd0);
        chk({tag, ".zero_out"}, 64'(zero_out), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int n_late;
        //        idx op     a                      rs2              imm     src rd  rw mr mw m2r expected
        setv( 0, 4'd0,  64'd5,                 64'd7,           64'd0,  0, 3,  1, 0, 0, 0, 64'd12);
        setv( 1, 4'd1,  64'd9,                 64'd3,           64'd9,  1, 4,  1, 0, 0, 0, 64'd0);
        setv( 2, 4'd7,  64'hFFFF_FFFF_FFFF_FFF8, 64'd1,         64'd0,  0, 5,  1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC);
        setv( 3, 4'd8,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1,         64'd0,  0, 6,  1, 0, 0, 0, 64'd1);
        setv( 4, 4'd9,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1,         64'd0,  0, 6,  1, 0, 0, 0, 64'd0);
        setv( 5, 4'd2,  64'hF0F0,              64'hFF00,        64'd0,  0, 8,  1, 0, 0, 0, 64'hF000);
        setv( 6, 4'd3,  64'hF0F0,              64'hFF00,        64'd0,  0, 9,  1, 0, 0, 0, 64'hFFF0);
        setv( 7, 4'd4,  64'hF0F0,              64'hFF00,        64'd0,  0, 10, 1, 0, 0, 0, 64'h0FF0);
        setv( 8, 4'd5,  64'd1,                 64'd63,          64'd0,  0, 11, 1, 0, 0, 0, 64'h8000_0000_0000_0000);
        setv( 9, 4'd5,  64'd1,                 64'd65,          64'd0,  0, 11, 1, 0, 0, 0, 64'd2);
        setv(10, 4'd6,  64'h8000_0000_0000_0000, 64'd63,        64'd0,  0, 12, 1, 0, 0, 0, 64'd1);
        setv(11, 4'd10, 64'd99,                64'd0,           64'h1234, 1, 13, 1, 0, 0, 0, 64'h1234);
        setv(12, 4'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1,         64'd0,  0, 14, 1, 0, 0, 0, 64'd0);
        setv(13, 4'd0,  64'd2,                 64'd3,           64'd0,  0, 0,  1, 0, 0, 0, 64'd5);
        setv(14, 4'd0,  64'h100,               64'hABCD,        64'd8,  1, 0,  0, 0, 1, 0, 64'h108);
        setv(15, 4'd13, 64'd5,                 64'd6,           64'd0,  0, 5,  1, 1, 0, 1, 64'd0);

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        #2 chk("reset.stall_out", 64'(stall_out), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            push_exp(vecs[i]);
            #3 chk($sformatf("vec%0d.stall_out", i), 64'(stall_out), 64'd0);
            @(posedge clk); #1;
            check_out($sformatf("vec%0d", i));
        end

        idle_inputs();
        @(posedge clk); #1;
        chk("idle.valid_out", 64'(valid_out), 64'd0);

        run_mul("mul_3x5", 64'd3, 64'd5, 64'd15);
        run_mul("mul_ffx2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
        run_mul("mul_wide", 64'h1_0000_0001, 64'h1_0000_0001, 64'h2_0000_0001);

        // Flush coinciding with a MUL launch: no stall, no start.
        v = mk_mul(64'd2, 64'd3, 64'd6);
        drive(v);
        flush_in = 1'b1;
        #3 chk("flush_idle.stall_out", 64'(stall_out), 64'd0);
        @(posedge clk); #1;
        chk("flush_idle.valid_out", 64'(valid_out), 64'd0);
        idle_inputs();
        #2 chk("flush_idle.not_started", 64'(stall_out), 64'd0);
        @(posedge clk); #1;

        // Flush in the middle of an iteration aborts the multiply.
        v = mk_mul(64'd7, 64'd9, 64'd63);
        drive(v);
        repeat (20) @(posedge clk);
        #1;
        chk("flush_busy.stall_before", 64'(stall_out), 64'd1);
        flush_in = 1'b1;
        #2 chk("flush_busy.stall_out", 64'(stall_out), 64'd0);
        @(posedge clk); #1;
        chk("flush_busy.valid_out", 64'(valid_out), 64'd0);
        flush_in = 1'b0;
        v.op = 4'd0; v.a = 64'd1; v.rs2 = 64'd1; v.rd = 5'd2; v.exp_res = 64'd2;
        drive(v);
        push_exp(v);
        #3 chk("post_flush_add.stall_out", 64'(stall_out), 64'd0);
        @(posedge clk); #1;
        check_out("post_flush_add");
        idle_inputs();
        n_late = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (valid_out) n_late++;
        end
        chk("flush_busy.no_late_result", 64'(n_late), 64'd0);

        // Reset in the middle of an iteration.
        v = mk_mul(64'd6, 64'd7, 64'd42);
        drive(v);
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        check_all_zero("rst_busy");
        #2 chk("rst_busy.state_idle", 64'(stall_out), 64'd0);
        rst = 1'b0;
        run_mul("mul_4x4_after_rst", 64'd4, 64'd4, 64'd16);
        idle_inputs();
        @(posedge clk); #1;
        chk("end.scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
